// File: rtl/pe_pixel_loader.sv
// pe_pixel_loader: upstream feeder and downstream collector for one pe element.
// Packs a serial RGB stream into pe's flat buses, pulses Start_BgRemoval, waits
// for Done, answers with Ack, then replays pe's outputs as a serial result stream.
// Optional feature macro: PE_LOADER_TIMEOUT_EN (bounded WAIT with sticky timeout_err).
module pe_pixel_loader #(
  parameter int NUM_PIXELS     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [7:0]              pix_r,
  input  logic [7:0]              pix_g,
  input  logic [7:0]              pix_b,
  output logic [8*NUM_PIXELS-1:0] red_in,
  output logic [8*NUM_PIXELS-1:0] green_in,
  output logic [8*NUM_PIXELS-1:0] blue_in,
  output logic                    Start_BgRemoval,
  input  logic                    Done,
  output logic                    Ack,
  input  logic [8*NUM_PIXELS-1:0] pe_red,
  input  logic [8*NUM_PIXELS-1:0] pe_green,
  input  logic [8*NUM_PIXELS-1:0] pe_blue,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [7:0]              res_r,
  output logic [7:0]              res_g,
  output logic [7:0]              res_b,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CW = $clog2(NUM_PIXELS + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t                  state_r;
  state_t                  state_next_s;
  logic [CW-1:0]           wr_idx_r;
  logic [CW-1:0]           wr_idx_next_s;
  logic [CW-1:0]           rd_idx_r;
  logic [CW-1:0]           rd_idx_next_s;
  logic                    accept_s;
  logic                    drain_hs_s;
  logic                    timeout_hit_s;

  logic [8*NUM_PIXELS-1:0] red_in_r;
  logic [8*NUM_PIXELS-1:0] green_in_r;
  logic [8*NUM_PIXELS-1:0] blue_in_r;
  logic [8*NUM_PIXELS-1:0] res_red_r;
  logic [8*NUM_PIXELS-1:0] res_green_r;
  logic [8*NUM_PIXELS-1:0] res_blue_r;

  logic [7:0]              sel_r_s;
  logic [7:0]              sel_g_s;
  logic [7:0]              sel_b_s;

  logic                    pix_ready_r;
  logic                    start_r;
  logic                    ack_r;
  logic                    res_valid_r;
  logic [7:0]              res_r_r;
  logic [7:0]              res_g_r;
  logic [7:0]              res_b_r;
  logic                    busy_r;

  // Handshakes are qualified by state so stray valid/ready outside FILL/DRAIN do nothing.
  assign accept_s   = pix_valid && (state_r == ST_FILL);
  assign drain_hs_s = res_ready && (state_r == ST_DRAIN);

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode for the FILL -> START -> WAIT -> ACK -> DRAIN cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (accept_s && (wr_idx_r == LAST_IDX)) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_START: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (Done) begin
          state_next_s = ST_ACK;
        end else if (timeout_hit_s) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ACK: state_next_s = ST_DRAIN;
      ST_DRAIN: begin
        if (drain_hs_s && (rd_idx_r == LAST_IDX)) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_FILL;
    endcase
  end

  // Write/read slot pointers; each wraps to 0 on the last slot of a batch.
  always_comb begin
    wr_idx_next_s = wr_idx_r;
    rd_idx_next_s = rd_idx_r;
    if (accept_s) begin
      if (wr_idx_r == LAST_IDX) begin
        wr_idx_next_s = {CW{1'b0}};
      end else begin
        wr_idx_next_s = wr_idx_r + CW'(1);
      end
    end else begin
      wr_idx_next_s = wr_idx_r;
    end
    if (drain_hs_s) begin
      if (rd_idx_r == LAST_IDX) begin
        rd_idx_next_s = {CW{1'b0}};
      end else begin
        rd_idx_next_s = rd_idx_r + CW'(1);
      end
    end else begin
      rd_idx_next_s = rd_idx_r;
    end
  end

  // Pointer registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_idx_r <= {CW{1'b0}};
      rd_idx_r <= {CW{1'b0}};
    end else begin
      wr_idx_r <= wr_idx_next_s;
      rd_idx_r <= rd_idx_next_s;
    end
  end

  // Pack accepted pixels into the flat buses; only FILL writes, so they hold through the batch.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_in_r   <= '0;
      green_in_r <= '0;
      blue_in_r  <= '0;
    end else if (accept_s) begin
      for (int k = 0; k < NUM_PIXELS; k++) begin
        if (wr_idx_r == CW'(k)) begin
          red_in_r[8*k +: 8]   <= pix_r;
          green_in_r[8*k +: 8] <= pix_g;
          blue_in_r[8*k +: 8]  <= pix_b;
        end
      end
    end
  end

  // Capture pe's results on the cycle Done is seen in WAIT.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      res_red_r   <= '0;
      res_green_r <= '0;
      res_blue_r  <= '0;
    end else if ((state_r == ST_WAIT) && Done) begin
      res_red_r   <= pe_red;
      res_green_r <= pe_green;
      res_blue_r  <= pe_blue;
    end
  end

  // Select the result slot that will be presented next cycle.
  always_comb begin
    sel_r_s = 8'd0;
    sel_g_s = 8'd0;
    sel_b_s = 8'd0;
    for (int k = 0; k < NUM_PIXELS; k++) begin
      if (rd_idx_next_s == CW'(k)) begin
        sel_r_s = res_red_r[8*k +: 8];
        sel_g_s = res_green_r[8*k +: 8];
        sel_b_s = res_blue_r[8*k +: 8];
      end else begin
        sel_r_s = sel_r_s;
        sel_g_s = sel_g_s;
        sel_b_s = sel_b_s;
      end
    end
  end

  // Registered control/result outputs, decoded from the next state so they align with it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_ready_r <= 1'b1;
      start_r     <= 1'b0;
      ack_r       <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      res_r_r     <= 8'd0;
      res_g_r     <= 8'd0;
      res_b_r     <= 8'd0;
    end else begin
      pix_ready_r <= (state_next_s == ST_FILL);
      start_r     <= (state_next_s == ST_START);
      ack_r       <= (state_next_s == ST_ACK);
      res_valid_r <= (state_next_s == ST_DRAIN);
      busy_r      <= (state_next_s != ST_FILL);
      if (state_next_s == ST_DRAIN) begin
        res_r_r <= sel_r_s;
        res_g_r <= sel_g_s;
        res_b_r <= sel_b_s;
      end else begin
        res_r_r <= 8'd0;
        res_g_r <= 8'd0;
        res_b_r <= 8'd0;
      end
    end
  end

`ifdef PE_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt_r;
  logic          timeout_err_r;

  // The last allowed WAIT cycle without Done abandons the batch.
  assign timeout_hit_s = (state_r == ST_WAIT) && !Done && (wait_cnt_r == TO_LAST);

  // WAIT cycle counter, held at zero outside WAIT so every entry starts fresh.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt_r <= {TW{1'b0}};
    end else if (state_r == ST_WAIT) begin
      wait_cnt_r <= wait_cnt_r + TW'(1);
    end else begin
      wait_cnt_r <= {TW{1'b0}};
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timeout_err_r <= 1'b0;
    end else if (timeout_hit_s) begin
      timeout_err_r <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_r;
`else
  assign timeout_hit_s = 1'b0;
  // Constant-folds to 0; WAIT is unbounded in this build.
  assign timeout_err   = (TIMEOUT_CYCLES < 0);
`endif

  assign pix_ready       = pix_ready_r;
  assign red_in          = red_in_r;
  assign green_in        = green_in_r;
  assign blue_in         = blue_in_r;
  assign Start_BgRemoval = start_r;
  assign Ack             = ack_r;
  assign res_valid       = res_valid_r;
  assign res_r           = res_r_r;
  assign res_g           = res_g_r;
  assign res_b           = res_b_r;
  assign busy            = busy_r;

endmodule

// File: tb/tb_pe_pixel_loader.sv
// Testbench for pe_pixel_loader: a 4-pixel instance with a behavioural pe model
// and scoreboard queue, plus a 1-pixel instance for the single-slot boundary.
module tb_pe_pixel_loader;

  logic        Clk;
  logic        Reset_n;

  logic        pix_valid, pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [31:0] red_in, green_in, blue_in;
  logic        Start_BgRemoval, Done, Ack;
  logic [31:0] pe_red, pe_green, pe_blue;
  logic        res_valid, res_ready;
  logic [7:0]  res_r, res_g, res_b;
  logic        busy, timeout_err;

  logic        pix_valid1, pix_ready1;
  logic [7:0]  pix_r1, pix_g1, pix_b1;
  logic [7:0]  red_in1, green_in1, blue_in1;
  logic        Start1, Done1, Ack1;
  logic [7:0]  pe_red1, pe_green1, pe_blue1;
  logic        res_valid1, res_ready1;
  logic [7:0]  res_r1, res_g1, res_b1;
  logic        busy1, timeout_err1;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;
  logic [23:0] sb_q[$];

  bit          pe_auto = 1'b1;
  bit          pe_override = 1'b0;
  int          pe_lat = 2;
  logic [31:0] ovr_r, ovr_g, ovr_b;

  pe_pixel_loader #(.NUM_PIXELS(4), .TIMEOUT_CYCLES(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .Start_BgRemoval(Start_BgRemoval), .Done(Done), .Ack(Ack),
    .pe_red(pe_red), .pe_green(pe_green), .pe_blue(pe_blue),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_r(res_r), .res_g(res_g), .res_b(res_b),
    .busy(busy), .timeout_err(timeout_err)
  );

  pe_pixel_loader #(.NUM_PIXELS(1), .TIMEOUT_CYCLES(8)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .pix_valid(pix_valid1), .pix_ready(pix_ready1),
    .pix_r(pix_r1), .pix_g(pix_g1), .pix_b(pix_b1),
    .red_in(red_in1), .green_in(green_in1), .blue_in(blue_in1),
    .Start_BgRemoval(Start1), .Done(Done1), .Ack(Ack1),
    .pe_red(pe_red1), .pe_green(pe_green1), .pe_blue(pe_blue1),
    .res_valid(res_valid1), .res_ready(res_ready1),
    .res_r(res_r1), .res_g(res_g1), .res_b(res_b1),
    .busy(busy1), .timeout_err(timeout_err1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // pe model: after Start, wait pe_lat cycles, present results and pulse Done.
  initial begin
    forever begin
      @(negedge Clk);
      if (pe_auto && Start_BgRemoval === 1'b1) begin
        repeat (pe_lat) @(negedge Clk);
        if (pe_override) begin
          pe_red = ovr_r; pe_green = ovr_g; pe_blue = ovr_b;
        end else begin
          pe_red = ~red_in; pe_green = ~green_in; pe_blue = ~blue_in;
        end
        Done = 1'b1;
        @(negedge Clk);
        Done = 1'b0;
      end
    end
  end

  // Ack pulse counter for the 4-pixel instance.
  initial begin
    forever begin
      @(negedge Clk);
      if (Ack === 1'b1) ack_cnt++;
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_batch(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                            input bit push_inv, input string tag);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        checks++;
        if (pix_ready !== 1'b1) begin
          errors++; $display("FAIL %s_ready: pix_ready=%b, expected 1", tag, pix_ready);
        end
      end
      pix_valid = 1'b1;
      pix_r = r[8*i +: 8]; pix_g = g[8*i +: 8]; pix_b = b[8*i +: 8];
      if (push_inv) sb_q.push_back({~r[8*i +: 8], ~g[8*i +: 8], ~b[8*i +: 8]});
    end
    @(negedge Clk);
    pix_valid = 1'b0;
    checks++;
    if (Start_BgRemoval !== 1'b1) begin
      errors++; $display("FAIL %s_start: Start=%b, expected 1 after last accept", tag, Start_BgRemoval);
    end
    checks++;
    if ({red_in, green_in, blue_in} !== {r, g, b}) begin
      errors++; $display("FAIL %s_pack: got %h %h %h, expected %h %h %h", tag, red_in, green_in, blue_in, r, g, b);
    end
    @(negedge Clk);
    checks++;
    if (Start_BgRemoval !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s_start_pulse: Start=%b busy=%b, expected 0 1", tag, Start_BgRemoval, busy);
    end
  endtask

  task automatic drain_results(input int n, input string tag);
    int waited = 0;
    logic [23:0] exp_v;
    while (res_valid !== 1'b1 && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL %s_valid: res_valid=%b, expected 1 within 50 cycles", tag, res_valid);
      return;
    end
    res_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) pix_valid = 1'b0;
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : 24'hXXXXXX;
      checks++;
      if (res_valid !== 1'b1 || {res_r, res_g, res_b} !== exp_v) begin
        errors++; $display("FAIL %s_result%0d: valid=%b rgb=%h, expected 1 %h", tag, i, res_valid, {res_r, res_g, res_b}, exp_v);
      end
      @(negedge Clk);
    end
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL %s_end: busy=%b res_valid=%b, expected 0 0", tag, busy, res_valid);
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({pix_ready, Start_BgRemoval, Ack, res_valid, busy, timeout_err} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl: rdy/start/ack/valid/busy/to=%b, expected 100000",
                         {pix_ready, Start_BgRemoval, Ack, res_valid, busy, timeout_err});
    end
    checks++;
    if ({red_in, green_in, blue_in, res_r, res_g, res_b} !== 120'd0) begin
      errors++; $display("FAIL reset_data: buses nonzero %h", {red_in, green_in, blue_in, res_r, res_g, res_b});
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_fill_pack;
    int ack0 = ack_cnt;
    send_batch(32'h01462_80A, 32'h02503214, 32'h035A3C1E, 1'b1, "t1");
    drain_results(4, "t1");
    checks++;
    if (ack_cnt - ack0 !== 1) begin
      errors++; $display("FAIL t1_ack: ack pulses=%0d, expected 1", ack_cnt - ack0);
    end
  endtask

  task automatic test_pix_valid_outside_fill;
    int w = 0;
    pe_lat = 4;
    send_batch(32'h44332211, 32'h88776655, 32'hCCBBAA99, 1'b1, "t3");
    pix_valid = 1'b1; pix_r = 8'hEE; pix_g = 8'hEE; pix_b = 8'hEE;
    while (res_valid !== 1'b1 && w < 30) begin
      checks++;
      if (pix_ready !== 1'b0 || red_in !== 32'h44332211) begin
        errors++; $display("FAIL t3_ignore: pix_ready=%b red_in=%h, expected 0 44332211", pix_ready, red_in);
      end
      @(negedge Clk);
      w++;
    end
    drain_results(4, "t3");
    pe_lat = 2;
  endtask

  task automatic test_stall;
    int w = 0;
    pe_override = 1'b1;
    ovr_r = 32'hAABBCCDD; ovr_g = 32'h11223344; ovr_b = 32'h55667788;
    sb_q.push_back(24'hDD4488); sb_q.push_back(24'hCC3377);
    sb_q.push_back(24'hBB2266); sb_q.push_back(24'hAA1155);
    send_batch(32'h0D0C0B0A, 32'h1D1C1B1A, 32'h2D2C2B2A, 1'b0, "t2");
    while (res_valid !== 1'b1 && w < 30) begin
      @(negedge Clk);
      w++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_r !== 8'hDD || busy !== 1'b1) begin
        errors++; $display("FAIL t2_stall%0d: valid=%b res_r=%h busy=%b, expected 1 dd 1", i, res_valid, res_r, busy);
      end
      @(negedge Clk);
    end
    drain_results(4, "t2");
    pe_override = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    int ack0;
    pe_auto = 1'b0;
    send_batch(32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 1'b0, "t4");
    ack0 = ack_cnt;
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    checks++;
    if ({pix_ready, Start_BgRemoval, Ack, res_valid, busy} !== 5'b10000 || red_in !== 32'd0) begin
      errors++; $display("FAIL t4_async: rdy/start/ack/valid/busy=%b red_in=%h, expected 10000 0",
                         {pix_ready, Start_BgRemoval, Ack, res_valid, busy}, red_in);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (ack_cnt !== ack0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
      errors++; $display("FAIL t4_after: ack pulses=%0d busy=%b rdy=%b, expected %0d 0 1", ack_cnt, busy, pix_ready, ack0);
    end
    pe_auto = 1'b1;
  endtask

  task automatic test_single_pixel;
    @(negedge Clk);
    Done1 = 1'b1;
    pe_red1 = 8'h5A; pe_green1 = 8'hA5; pe_blue1 = 8'h3C;
    checks++;
    if (pix_ready1 !== 1'b1) begin
      errors++; $display("FAIL t5_ready: pix_ready=%b, expected 1", pix_ready1);
    end
    pix_valid1 = 1'b1; pix_r1 = 8'h21; pix_g1 = 8'h43; pix_b1 = 8'h65;
    @(negedge Clk);
    pix_valid1 = 1'b0;
    checks++;
    if (Start1 !== 1'b1 || {red_in1, green_in1, blue_in1} !== 24'h214365 || Ack1 !== 1'b0) begin
      errors++; $display("FAIL t5_start: start=%b ack=%b bus=%h, expected 1 0 214365", Start1, Ack1, {red_in1, green_in1, blue_in1});
    end
    @(negedge Clk);
    checks++;
    if (Start1 !== 1'b0 || Ack1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL t5_wait: start=%b ack=%b busy=%b, expected 0 0 1", Start1, Ack1, busy1);
    end
    @(negedge Clk);
    checks++;
    if (Ack1 !== 1'b1) begin
      errors++; $display("FAIL t5_ack: ack=%b, expected 1 on cycle after first WAIT", Ack1);
    end
    Done1 = 1'b0;
    res_ready1 = 1'b1;
    @(negedge Clk);
    checks++;
    if (res_valid1 !== 1'b1 || {res_r1, res_g1, res_b1} !== 24'h5AA53C || Ack1 !== 1'b0) begin
      errors++; $display("FAIL t5_result: valid=%b rgb=%h ack=%b, expected 1 5aa53c 0", res_valid1, {res_r1, res_g1, res_b1}, Ack1);
    end
    @(negedge Clk);
    res_ready1 = 1'b0;
    checks++;
    if (res_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL t5_end: valid=%b busy=%b, expected 0 0", res_valid1, busy1);
    end
  endtask

`ifdef PE_LOADER_TIMEOUT_EN
  task automatic test_timeout;
    int ack0;
    pe_auto = 1'b0;
    ack0 = ack_cnt;
    send_batch(32'h0A0B0C0D, 32'h01020304, 32'h05060708, 1'b0, "t6");
    repeat (7) @(negedge Clk);
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL t6_wait8: timeout_err=%b busy=%b, expected 0 1", timeout_err, busy);
    end
    @(negedge Clk);
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0 || pix_ready !== 1'b1 || ack_cnt !== ack0) begin
      errors++; $display("FAIL t6_fire: to=%b busy=%b rdy=%b acks=%0d, expected 1 0 1 %0d", timeout_err, busy, pix_ready, ack_cnt, ack0);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++; $display("FAIL t6_sticky: timeout_err=%b, expected 1", timeout_err);
    end
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL t6_clear: timeout_err=%b, expected 0 after reset", timeout_err);
    end
    Reset_n = 1'b1;
    pe_auto = 1'b1;
  endtask
`endif

  initial begin
    Reset_n = 1'b0;
    pix_valid = 1'b0; pix_r = 8'd0; pix_g = 8'd0; pix_b = 8'd0;
    Done = 1'b0; pe_red = 32'd0; pe_green = 32'd0; pe_blue = 32'd0;
    res_ready = 1'b0;
    pix_valid1 = 1'b0; pix_r1 = 8'd0; pix_g1 = 8'd0; pix_b1 = 8'd0;
    Done1 = 1'b0; pe_red1 = 8'd0; pe_green1 = 8'd0; pe_blue1 = 8'd0;
    res_ready1 = 1'b0;
    ovr_r = 32'd0; ovr_g = 32'd0; ovr_b = 32'd0;

    test_reset();
    test_fill_pack();
    test_pix_valid_outside_fill();
    test_stall();
    test_reset_mid_wait();
    test_single_pixel();
`ifdef PE_LOADER_TIMEOUT_EN
    test_timeout();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
